mem_port_arbiter: RTL

- Two-requester arbiter that shares the single physical-memory port between the instruction cache (I side, read-only) and the data cache (D side, read/write).
- Sits between the two caches and the physical memory model/controller.
- Latches the granted request's address and write data into holding registers, so the memory port sees stable values for the whole transaction.
- Round-robin tie-break prevents starvation of either side.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/register.sv | 20 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D cache memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_I    = 2'd1,
        SERVE_D_RD = 2'd2,
        SERVE_D_WR = 2'd3
    } arb_state_t;

    // Side encoding for the round-robin last_grant flag.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/register.sv
// Generic loadable holding register, no built-in reset (callers mux in clear values).
// Latency: 1 cycle from load to out.
// Backpressure: none; holds its value whenever load is low.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Capture in on load, otherwise hold.
    always_ff @(posedge clk) begin
        if (load) begin
            out <= in;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the I cache (read) and D cache (read/write).
// Latency: 1 grant cycle + memory latency; resp is coincident with pmem_resp.
// Backpressure: requesters hold their request until resp; strobes hold until pmem_resp.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  last_grant;
    logic                  grant;
    logic                  grant_side;
    logic                  d_req;
    logic                  addr_load;
    logic                  wdata_load;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [LINE_WIDTH-1:0] wdata_in;

    assign d_req = d_read | d_write;

    // Next-state and grant decision; a tie goes to the side that was not granted last.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_side = GRANT_I;
        case (state)
            IDLE: begin
                if (i_read && (!d_req || last_grant == GRANT_D)) begin
                    state_next = SERVE_I;
                    grant      = 1'b1;
                    grant_side = GRANT_I;
                end else if (d_req) begin
                    // A write wins over a simultaneous read on the D side.
                    state_next = d_write ? SERVE_D_WR : SERVE_D_RD;
                    grant      = 1'b1;
                    grant_side = GRANT_D;
                end
            end
            default: begin
                if (pmem_resp) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // State register and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GRANT_D;
        end else begin
            state <= state_next;
            if (grant) begin
                last_grant <= grant_side;
            end
        end
    end

    // Holding registers: cleared by forcing a load of zero during reset.
    assign addr_load  = rst | grant;
    assign addr_in    = rst ? '0 : ((grant_side == GRANT_D) ? d_addr : i_addr);
    assign wdata_load = rst | (grant && state_next == SERVE_D_WR);
    assign wdata_in   = rst ? '0 : d_wdata;

    register #(.WIDTH(ADDR_WIDTH)) u_addr_reg (
        .clk  (clk),
        .load (addr_load),
        .in   (addr_in),
        .out  (pmem_addr)
    );

    register #(.WIDTH(LINE_WIDTH)) u_wdata_reg (
        .clk  (clk),
        .load (wdata_load),
        .in   (wdata_in),
        .out  (pmem_wdata)
    );

    // Moore strobes from state; completion pulses qualified by pmem_resp; all quiet in reset.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        if (!rst) begin
            case (state)
                SERVE_I: begin
                    pmem_read = 1'b1;
                    i_resp    = pmem_resp;
                end
                SERVE_D_RD: begin
                    pmem_read = 1'b1;
                    d_resp    = pmem_resp;
                end
                SERVE_D_WR: begin
                    pmem_write = 1'b1;
                    d_resp     = pmem_resp;
                end
                default: ;
            endcase
        end
    end

    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
